// File: rtl/wash_panel_if.sv
// wash_panel_if: signal bundle between the front panel and its surroundings.
//   Parameter CNT_W: width of cycle_count (must match the controller's CNT_W).
//   Panel inputs : start_btn, door_sw (raw, asynchronous), prog_sel[1:0],
//                  door_lock, done (from the wash-cycle FSM).
//   Panel outputs: start, door_close, busy, fault, prog_latched[1:0],
//                  cycle_count[CNT_W-1:0], state_dbg[2:0] (current panel state).
// Handshake with the cycle FSM: start is a level request held until door_lock=1
// acknowledges it; done is a single-cycle pulse while door_lock is still high.
// modport slave  : the controller (receives panel/FSM inputs, drives outputs).
// modport master : the environment (buttons, selector, cycle FSM).
interface wash_panel_if #(
  parameter int CNT_W = 16
);
  logic             start_btn;
  logic             door_sw;
  logic [1:0]       prog_sel;
  logic             door_lock;
  logic             done;
  logic             start;
  logic             door_close;
  logic             busy;
  logic             fault;
  logic [1:0]       prog_latched;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       state_dbg;

  modport slave (
    input  start_btn, door_sw, prog_sel, door_lock, done,
    output start, door_close, busy, fault, prog_latched, cycle_count, state_dbg
  );

  modport master (
    output start_btn, door_sw, prog_sel, door_lock, done,
    input  start, door_close, busy, fault, prog_latched, cycle_count, state_dbg
  );
endinterface

// File: rtl/wash_panel_ctrl.sv
// wash_panel_ctrl: front-panel stage ahead of the wash-cycle FSM.
//   Synchronizes and debounces start_btn and door_sw, latches prog_sel on a
//   start request, drives start/door_close to the cycle FSM, tracks progress
//   via door_lock/done, raises fault on handshake errors and counts cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - wash_panel_if.slave (see interface header for signal list)
// Parameters: DEBOUNCE_CYCLES (>=2), REQ_TIMEOUT (>=3), CNT_W.
// Build option: define WASH_PANEL_CYCLE_COUNT_EN to implement the saturating
//   completed-cycle counter; otherwise cycle_count is tied to zero.
module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REQ_TIMEOUT     = 8,
  parameter int CNT_W           = 16
) (
  input  logic         clk,
  input  logic         rst,
  wash_panel_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(REQ_TIMEOUT);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(REQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQUEST  = 3'd1,
    S_RUNNING  = 3'd2,
    S_COMPLETE = 3'd3,
    S_FAULT    = 3'd4
  } state_e;

  // Channel 0 = start button, channel 1 = door switch.
  logic [1:0]    raw_in;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic          btn_prev_q;
  logic          btn_rise;
  logic          door_close;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    prog_q, prog_d;
  logic          start_q, busy_q, fault_q;

  assign raw_in = {bus.door_sw, bus.start_btn};

  // A debounced value flips only after DEBOUNCE_CYCLES back-to-back samples
  // disagree with it; one agreeing sample restarts the run.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      btn_prev_q <= 1'b0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      btn_prev_q <= deb_q[0];
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign btn_rise   = deb_q[0] & ~btn_prev_q;
  assign door_close = deb_q[1];

  // Next-state logic. REQUEST priority: lock ack, then door open, then timeout.
  // RUNNING priority: done, then loss of door_lock.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    prog_d  = prog_q;
    case (state_q)
      S_IDLE: begin
        if (btn_rise && door_close) begin
          state_d = S_REQUEST;
          prog_d  = bus.prog_sel;
          timer_d = '0;
        end
      end
      S_REQUEST: begin
        if (bus.door_lock)          state_d = S_RUNNING;
        else if (!door_close)       state_d = S_IDLE;
        else if (timer_q == TO_LAST) state_d = S_FAULT;
        else                        timer_d = timer_q + TW'(1);
      end
      S_RUNNING: begin
        if (bus.done)               state_d = S_COMPLETE;
        else if (!bus.door_lock)    state_d = S_FAULT;
      end
      S_COMPLETE: state_d = S_IDLE;
      S_FAULT: begin
        // The clearing press is consumed here; a fresh press is needed to start.
        if (btn_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      prog_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prog_q  <= prog_d;
      start_q <= (state_d == S_REQUEST);
      busy_q  <= (state_d == S_REQUEST) || (state_d == S_RUNNING);
      fault_q <= (state_d == S_FAULT);
    end
  end

`ifdef WASH_PANEL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // COMPLETE is entered exactly once per finished cycle; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_COMPLETE && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.cycle_count = cnt_q;
`else
  assign bus.cycle_count = '0;
`endif

  assign bus.start        = start_q;
  assign bus.door_close   = door_close;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.prog_latched = prog_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// tb_wash_panel_ctrl: directed + randomized bench for wash_panel_ctrl.
// A simple cycle-FSM model raises door_lock one cycle after it sees start.
// Expected timing comes from the panel rules: debounce latency 2+DEB, one more
// cycle for the registered request, start held 2 cycles when acknowledged,
// REQ_TO cycles when not. A narrow CNT_W makes saturation reachable.
module tb_wash_panel_ctrl;
  localparam int DEB       = 4;
  localparam int REQ_TO    = 8;
  localparam int CNT_W     = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int DEB_LAT   = 2 + DEB;
  localparam int START_LAT = DEB_LAT + 1;
  localparam int SETTLE    = DEB_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic auto_lock = 1'b1;
  logic start_seen = 1'b0;
  int   exp_count = 0;
  logic [1:0] exp_prog = 2'd0;
  logic [CNT_W-1:0] exp_q[$];

  wash_panel_if #(.CNT_W(CNT_W)) bus();

  wash_panel_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REQ_TIMEOUT(REQ_TO),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- checker ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---- reference model: completed-cycle counter ----
  task automatic model_complete();
`ifdef WASH_PANEL_CYCLE_COUNT_EN
    if (exp_count < CNT_MAX) exp_count++;
`else
    exp_count = 0;
`endif
    exp_q.push_back(CNT_W'(exp_count));
  endtask

  // ---- driver tasks ----
  // One clock; inputs change 1 time unit after the edge. The cycle-FSM model
  // acknowledges a start request seen on the previous sample.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_lock && start_seen) bus.door_lock = 1'b1;
    start_seen = bus.start;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return bus.start;
      1:       return bus.fault;
      default: return bus.busy;
    endcase
  endfunction

  // Ticks until the probed output equals val (bounded); n = ticks taken.
  task automatic wait_for(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (probe(sel) !== val && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Number of consecutive samples the probed output stays high (bounded).
  task automatic high_len(input int sel, input int budget, output int n);
    n = 0;
    while (probe(sel) === 1'b1 && n < budget) begin
      n++;
      tick();
    end
  endtask

  // Runs n ticks and counts samples with start high.
  task automatic count_start(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.start === 1'b1) highs++;
    end
  endtask

  // Short button blips, each narrower than the debounce window.
  task automatic glitch();
    int k;
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      bus.start_btn = 1'b1;
      ticks($urandom_range(1, DEB - 1));
      bus.start_btn = 1'b0;
      ticks($urandom_range(2, 4));
    end
  endtask

  // Press until start appears, then release.
  task automatic press(input string tag);
    int n;
    bus.start_btn = 1'b1;
    wait_for(0, 1'b1, 3 * START_LAT, n);
    check({tag, "_start_lat"}, 32'(n), 32'(START_LAT));
    bus.start_btn = 1'b0;
  endtask

  // Full start->run->done cycle. drop_mode: 0 keep lock at done,
  // 1 drop lock together with done, 2 random.
  task automatic run_cycle(input string tag, input int drop_mode);
    int n;
    logic [1:0] p;
    logic drop;
    p = 2'($urandom_range(0, 3));
    bus.prog_sel = p;
    glitch();
    press(tag);
    exp_prog = p;
    check({tag, "_prog"}, 32'(bus.prog_latched), 32'(exp_prog));
    check({tag, "_busy_req"}, 32'(bus.busy), 32'd1);
    high_len(0, 4 * REQ_TO, n);
    check({tag, "_start_len"}, 32'(n), 32'd2);
    bus.prog_sel = 2'($urandom_range(0, 3));
    ticks($urandom_range(1, 6));
    check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    check({tag, "_prog_hold"}, 32'(bus.prog_latched), 32'(exp_prog));
    drop = (drop_mode == 2) ? 1'($urandom_range(0, 1)) : (drop_mode == 1);
    bus.done = 1'b1;
    if (drop) bus.door_lock = 1'b0;
    tick();
    bus.done = 1'b0;
    bus.door_lock = 1'b0;
    model_complete();
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_fault_done"}, 32'(bus.fault), 32'd0);
    check({tag, "_count"}, 32'(bus.cycle_count), 32'(exp_q.pop_front()));
    ticks(SETTLE);
  endtask

  // ---- directed sequence ----
  initial begin
    int n;
    int highs;
    bus.start_btn = 1'b0;
    bus.door_sw   = 1'b0;
    bus.prog_sel  = 2'd0;
    bus.door_lock = 1'b0;
    bus.done      = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_door", 32'(bus.door_close), 32'd0);
    check("rst_prog", 32'(bus.prog_latched), 32'd0);
    check("rst_count", 32'(bus.cycle_count), 32'd0);
    rst = 1'b0;

    // door debounce latency boundary
    bus.door_sw = 1'b1;
    ticks(DEB_LAT - 1);
    check("door_lat_m1", 32'(bus.door_close), 32'd0);
    tick();
    check("door_lat", 32'(bus.door_close), 32'd1);

    // basic cycle
    run_cycle("t1", 0);

    // bouncing button: no request until a stable press
    bus.start_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.start_btn = ~bus.start_btn;
      ticks(2);
    end
    bus.start_btn = 1'b0;
    count_start(SETTLE, highs);
    check("bounce_no_start", 32'(highs), 32'd0);
    run_cycle("t2", 0);

    // randomized cycles; count saturates along the way
    for (int i = 0; i < 9; i++) run_cycle("rnd", 2);
    run_cycle("drop_with_done", 1);

    // done/door_lock while idle are ignored
    bus.done = 1'b1;
    bus.door_lock = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.door_lock = 1'b0;
    tick();
    check("idle_done_busy", 32'(bus.busy), 32'd0);
    check("idle_done_fault", 32'(bus.fault), 32'd0);
    check("idle_done_count", 32'(bus.cycle_count), 32'(exp_count));

    // door open: press ignored
    bus.door_sw = 1'b0;
    ticks(DEB_LAT + 1);
    check("open_door", 32'(bus.door_close), 32'd0);
    bus.start_btn = 1'b1;
    count_start(2 * START_LAT, highs);
    check("open_no_start", 32'(highs), 32'd0);
    check("open_fault", 32'(bus.fault), 32'd0);
    check("open_busy", 32'(bus.busy), 32'd0);
    bus.start_btn = 1'b0;
    ticks(SETTLE);
    bus.door_sw = 1'b1;
    ticks(SETTLE);

    // door opens during REQUEST: back to idle, no fault
    auto_lock = 1'b0;
    press("req_open");
    bus.door_sw = 1'b0;
    high_len(0, 4 * REQ_TO, n);
    check("req_open_len", 32'(n), 32'(DEB_LAT + 1));
    check("req_open_fault", 32'(bus.fault), 32'd0);
    check("req_open_busy", 32'(bus.busy), 32'd0);
    bus.door_sw = 1'b1;
    ticks(SETTLE);

    // request timeout -> fault, next press clears
    press("to");
    high_len(0, 4 * REQ_TO, n);
    check("to_start_len", 32'(n), 32'(REQ_TO));
    check("to_fault", 32'(bus.fault), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd0);
    ticks(SETTLE);
    check("to_fault_hold", 32'(bus.fault), 32'd1);
    bus.start_btn = 1'b1;
    wait_for(1, 1'b0, 3 * START_LAT, n);
    check("to_clear_lat", 32'(n), 32'(START_LAT));
    bus.start_btn = 1'b0;
    count_start(SETTLE, highs);
    check("to_clear_no_start", 32'(highs), 32'd0);
    auto_lock = 1'b1;

    // door_lock lost in RUNNING without done -> fault
    press("lock_loss");
    high_len(0, 4 * REQ_TO, n);
    check("lock_loss_len", 32'(n), 32'd2);
    ticks(2);
    bus.door_lock = 1'b0;
    tick();
    check("lock_loss_fault", 32'(bus.fault), 32'd1);
    check("lock_loss_busy", 32'(bus.busy), 32'd0);
    check("lock_loss_count", 32'(bus.cycle_count), 32'(exp_count));
    ticks(SETTLE);
    bus.start_btn = 1'b1;
    wait_for(1, 1'b0, 3 * START_LAT, n);
    check("lock_loss_clear", 32'(n), 32'(START_LAT));
    bus.start_btn = 1'b0;
    ticks(SETTLE);

    // reset while RUNNING: outputs drop immediately
    press("rst_run");
    high_len(0, 4 * REQ_TO, n);
    tick();
    check("rst_run_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_run_start", 32'(bus.start), 32'd0);
    check("rst_run_busy", 32'(bus.busy), 32'd0);
    check("rst_run_fault", 32'(bus.fault), 32'd0);
    check("rst_run_door", 32'(bus.door_close), 32'd0);
    check("rst_run_prog", 32'(bus.prog_latched), 32'd0);
    check("rst_run_count", 32'(bus.cycle_count), 32'd0);
    #1;
    rst = 1'b0;
    bus.door_lock = 1'b0;
    start_seen = 1'b0;
    exp_count = 0;
    exp_q.delete();
    ticks(DEB_LAT + 1);
    run_cycle("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
